// File: rtl/axi_read_arbiter_pkg.sv
// rtl/axi_read_arbiter_pkg.sv - shared AXI read-side definitions: FSM states, fixed AR attributes, requester indices
package axi_read_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } axi_state_e;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_LOCK_NORMAL = 2'b00;
    localparam logic [3:0] AXI_CACHE_NONE  = 4'b0000;
    localparam logic [2:0] AXI_PROT_NONE   = 3'b000;

    // Bit positions in request/grant vectors
    localparam int REQ_I = 0;
    localparam int REQ_D = 1;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
    } ar_fields_t;

endpackage

// File: rtl/axi_read_arbiter_rr_arbiter2.sv
// rtl/axi_read_arbiter_rr_arbiter2.sv - two-input round-robin grant with history updated on accept
module rr_arbiter2
    import axi_read_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] gnt
);

    // History: 1 means the data side (REQ_D) was granted last
    logic last_d_q;
    logic last_d_d;

    always_comb begin
        gnt      = req;
        last_d_d = last_d_q;
        if (req == 2'b11) begin
            gnt = last_d_q ? 2'b01 : 2'b10;
        end
        if (accept && (gnt != 2'b00)) begin
            last_d_d = gnt[REQ_D];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_d_q <= 1'b0;
        end else begin
            last_d_q <= last_d_d;
        end
    end

endmodule

// File: rtl/axi_read_arbiter.sv
// rtl/axi_read_arbiter.sv - arbitrates instruction and data read requesters onto one AXI read port, one burst at a time
module axi_read_arbiter
    import axi_read_arbiter_pkg::*;
#(
    parameter logic [3:0] I_ID = 4'd0,
    parameter logic [3:0] D_ID = 4'd1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_arvalid,
    input  logic [31:0] i_araddr,
    input  logic [7:0]  i_arlen,
    input  logic [2:0]  i_arsize,
    output logic        i_arready,
    output logic [31:0] i_rdata,
    output logic        i_rlast,
    output logic        i_rvalid,
    input  logic        i_rready,
    input  logic        d_arvalid,
    input  logic [31:0] d_araddr,
    input  logic [7:0]  d_arlen,
    input  logic [2:0]  d_arsize,
    output logic        d_arready,
    output logic [31:0] d_rdata,
    output logic        d_rlast,
    output logic        d_rvalid,
    input  logic        d_rready,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic        rid_err
);

    axi_state_e state_q, state_d;
    logic       owner_q, owner_d;      // 1 = data side owns the port
    ar_fields_t ar_q, ar_d;
    logic       rid_err_q, rid_err_d;
    logic [1:0] req;
    logic [1:0] gnt;
    logic [3:0] owner_id;
    logic       unused_rresp;

    assign req          = {d_arvalid, i_arvalid};
    assign owner_id     = owner_q ? D_ID : I_ID;
    assign unused_rresp = ^rresp;

    rr_arbiter2 u_rr (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .accept (state_q == ST_IDLE),
        .gnt    (gnt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            owner_q   <= 1'b0;
            ar_q      <= '0;
            rid_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            ar_q      <= ar_d;
            rid_err_q <= rid_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        ar_d      = ar_q;
        rid_err_d = rid_err_q;
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    state_d = ST_ADDR;
                    owner_d = gnt[REQ_D];
                    ar_d    = gnt[REQ_D] ? '{d_araddr, d_arlen, d_arsize}
                                         : '{i_araddr, i_arlen, i_arsize};
                end
            end
            ST_ADDR: begin
                if (arready) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (rvalid && rready && rlast) state_d = ST_IDLE;
                // Mismatched beats are flagged but still handed to the owner
                if (rvalid && (rid != owner_id)) rid_err_d = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        arvalid   = 1'b0;
        i_arready = 1'b0;
        d_arready = 1'b0;
        rready    = 1'b0;
        i_rvalid  = 1'b0;
        d_rvalid  = 1'b0;
        case (state_q)
            ST_ADDR: begin
                arvalid   = 1'b1;
                i_arready = arready & ~owner_q;
                d_arready = arready & owner_q;
            end
            ST_DATA: begin
                rready   = owner_q ? d_rready : i_rready;
                i_rvalid = rvalid & ~owner_q;
                d_rvalid = rvalid & owner_q;
            end
            default: ;
        endcase
    end

    assign arid    = owner_id;
    assign araddr  = ar_q.addr;
    assign arlen   = ar_q.len;
    assign arsize  = ar_q.size;
    assign arburst = AXI_BURST_INCR;
    assign arlock  = AXI_LOCK_NORMAL;
    assign arcache = AXI_CACHE_NONE;
    assign arprot  = AXI_PROT_NONE;
    assign rid_err = rid_err_q;

    assign i_rdata = rdata;
    assign d_rdata = rdata;
    assign i_rlast = rlast & ~owner_q;
    assign d_rlast = rlast & owner_q;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// tb/tb_axi_read_arbiter.sv - randomized self-checking bench for axi_read_arbiter against a transaction-level model
module tb_axi_read_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_arvalid, d_arvalid, i_rready, d_rready;
    logic [31:0] i_araddr, d_araddr;
    logic [7:0]  i_arlen, d_arlen;
    logic [2:0]  i_arsize, d_arsize;
    logic        i_arready, d_arready, i_rlast, d_rlast, i_rvalid, d_rvalid;
    logic [31:0] i_rdata, d_rdata;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize, arprot;
    logic [1:0]  arburst, arlock;
    logic [3:0]  arcache;
    logic        arvalid, arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready, rid_err;

    int n_checks = 0;
    int n_bad    = 0;
    bit last_was_d;
    bit rid_err_exp;

    axi_read_arbiter dut (
        .clk(clk), .reset(reset),
        .i_arvalid(i_arvalid), .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arsize(i_arsize),
        .i_arready(i_arready), .i_rdata(i_rdata), .i_rlast(i_rlast), .i_rvalid(i_rvalid), .i_rready(i_rready),
        .d_arvalid(d_arvalid), .d_araddr(d_araddr), .d_arlen(d_arlen), .d_arsize(d_arsize),
        .d_arready(d_arready), .d_rdata(d_rdata), .d_rlast(d_rlast), .d_rvalid(d_rvalid), .d_rready(d_rready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .rid_err(rid_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", n_checks, n_bad);
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entered at posedge+1 with the arbiter idle and this side's request already driven.
    task automatic do_txn(input bit side_d, input int max_delay);
        logic [3:0]  oid;
        logic [31:0] addr, salt, exp_data;
        logic [7:0]  len;
        logic [2:0]  size;
        int delay, beat, guard;
        bit own_rr, oth_rr, own_v, own_l;
        oid  = side_d ? 4'd1 : 4'd0;
        addr = side_d ? d_araddr : i_araddr;
        len  = side_d ? d_arlen : i_arlen;
        size = side_d ? d_arsize : i_arsize;
        salt = $urandom;
        arready = 1'b0;
        rvalid  = 1'b0;
        @(negedge clk);
        check_val("idle_arvalid", arvalid, 0);
        check_val("idle_rready", rready, 0);
        step();
        delay = $urandom_range(0, max_delay);
        for (int c = 0; c <= delay; c++) begin
            arready = (c == delay);
            @(negedge clk);
            check_val("arvalid", arvalid, 1);
            check_val("arid", arid, oid);
            check_val("araddr", araddr, addr);
            check_val("arlen", arlen, len);
            check_val("arsize", arsize, size);
            check_val("arburst", arburst, 2'b01);
            check_val("ar_attr", {arlock, arcache, arprot}, 0);
            check_val("own_arready", side_d ? d_arready : i_arready, c == delay);
            check_val("oth_arready", side_d ? i_arready : d_arready, 0);
            step();
        end
        arready = 1'b0;
        if (side_d) d_arvalid = 1'b0; else i_arvalid = 1'b0;
        beat  = 0;
        guard = 0;
        while (beat <= int'(len) && guard < 300) begin
            guard++;
            rvalid   = ($urandom_range(0, 3) != 0);
            own_rr   = ($urandom_range(0, 2) != 0);
            oth_rr   = $urandom_range(0, 1);
            rid      = ($urandom_range(0, 63) == 0) ? (oid ^ 4'd1) : oid;
            rresp    = 2'b00;
            exp_data = addr ^ salt ^ (beat << 8);
            rdata    = exp_data;
            rlast    = (beat == int'(len));
            d_rready = side_d ? own_rr : oth_rr;
            i_rready = side_d ? oth_rr : own_rr;
            @(negedge clk);
            own_v = side_d ? d_rvalid : i_rvalid;
            own_l = side_d ? d_rlast : i_rlast;
            check_val("own_rvalid", own_v, rvalid);
            check_val("oth_rvalid", side_d ? i_rvalid : d_rvalid, 0);
            check_val("rready", rready, own_rr);
            check_val("rid_err", rid_err, rid_err_exp);
            if (rvalid) begin
                check_val("own_rdata", side_d ? d_rdata : i_rdata, exp_data);
                check_val("own_rlast", own_l, beat == int'(len));
            end
            if (rvalid && rid != oid) rid_err_exp = 1'b1;
            if (rvalid && own_rr) beat++;
            step();
        end
        if (guard >= 300) check_val("data_timeout", guard, 0);
        rvalid     = 1'b0;
        last_was_d = side_d;
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            rvalid   = $urandom_range(0, 1);
            rid      = 4'($urandom_range(0, 15));
            i_rready = 1'b1;
            d_rready = 1'b1;
            @(negedge clk);
            check_val("gap_rready", rready, 0);
            check_val("gap_rvalid", {i_rvalid, d_rvalid}, 0);
            check_val("gap_arvalid", arvalid, 0);
            check_val("gap_rid_err", rid_err, rid_err_exp);
            step();
        end
        rvalid = 1'b0;
    endtask

    task automatic set_req(input bit side_d);
        if (side_d) begin
            d_arvalid = 1'b1;
            d_araddr  = $urandom & 32'hFFFF_FFFC;
            d_arlen   = 8'($urandom_range(0, 7));
            d_arsize  = 3'($urandom_range(0, 2));
        end else begin
            i_arvalid = 1'b1;
            i_araddr  = $urandom & 32'hFFFF_FFFC;
            i_arlen   = 8'($urandom_range(0, 7));
            i_arsize  = 3'($urandom_range(0, 2));
        end
    endtask

    initial begin
        bit first_d;
        int mode;
        reset = 1'b1;
        {i_arvalid, d_arvalid, i_rready, d_rready} = '0;
        {i_araddr, d_araddr, i_arlen, d_arlen, i_arsize, d_arsize} = '0;
        arready = 1'b1;
        rvalid  = 1'b1;
        rid = 4'd0; rdata = 32'h0; rresp = 2'b00; rlast = 1'b1;
        last_was_d  = 1'b0;
        rid_err_exp = 1'b0;
        step();
        step();
        @(negedge clk);
        check_val("rst_arvalid", arvalid, 0);
        check_val("rst_rready", rready, 0);
        check_val("rst_arready", {i_arready, d_arready}, 0);
        check_val("rst_rvalid", {i_rvalid, d_rvalid}, 0);
        check_val("rst_rid_err", rid_err, 0);
        step();
        reset   = 1'b0;
        arready = 1'b0;
        rvalid  = 1'b0;

        // Boot fetch: single instruction burst, address accepted at once
        i_arvalid = 1'b1; i_araddr = 32'h1FC0_0000; i_arlen = 8'd3; i_arsize = 3'd2;
        do_txn(1'b0, 0);

        for (int it = 0; it < 40; it++) begin
            mode = $urandom_range(1, 3);
            if (mode != 2) set_req(1'b0);
            if (mode != 1) set_req(1'b1);
            if (mode == 3) begin
                first_d = !last_was_d;
                do_txn(first_d, 5);
                do_txn(!first_d, 5);
            end else begin
                do_txn(mode == 2, 5);
            end
            idle_cycles($urandom_range(0, 2));
        end

        // Mid-burst reset after a mismatched-ID beat
        i_arvalid = 1'b1; i_araddr = 32'h0000_1000; i_arlen = 8'd3; i_arsize = 3'd2;
        step();
        arready = 1'b1;
        step();
        arready = 1'b0; i_arvalid = 1'b0;
        rvalid = 1'b1; i_rready = 1'b1; rlast = 1'b0; rid = 4'd1; rdata = 32'hCAFE_0000;
        @(negedge clk);
        check_val("wrong_rid_routed", {i_rvalid, i_rdata}, {1'b1, 32'hCAFE_0000});
        step();
        rid = 4'd0;
        @(negedge clk);
        check_val("rid_err_set", rid_err, 1);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        rid_err_exp = 1'b0;
        last_was_d  = 1'b0;
        @(negedge clk);
        check_val("mid_rst_arvalid", arvalid, 0);
        check_val("mid_rst_rready", rready, 0);
        check_val("mid_rst_rvalid", i_rvalid, 0);
        check_val("mid_rst_rid_err", rid_err, 0);
        step();
        rvalid = 1'b0;
        set_req(1'b0);
        set_req(1'b1);
        do_txn(1'b1, 2);
        do_txn(1'b0, 2);
        idle_cycles(2);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
